// File: rtl/dm_result_reader_if.sv
// Bundle of core-completion, data-memory read and result-stream signals
// for the post-run result unloader.
interface dm_result_reader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 12
);
  logic              end_process;
  logic              mem_sel;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    input  end_process,
    input  mem_data,
    input  out_ready,
    output mem_sel,
    output mem_rd_en,
    output mem_addr,
    output out_data,
    output out_valid,
    output out_last,
    output busy,
    output done
  );

  modport slave (
    output end_process,
    output mem_data,
    output out_ready,
    input  mem_sel,
    input  mem_rd_en,
    input  mem_addr,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  busy,
    input  done
  );
endinterface

// File: rtl/dm_result_reader.sv
// Unloads COUNT result words from data memory after the core finishes and
// streams them on a valid/ready port with a last-word marker.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a rising edge of end_process
// S_FETCH | read strobe out, mem_addr = BASE_ADDR + idx
// S_WAIT  | memory read latency; mem_data captured at end of cycle
// S_HOLD  | out_valid held until the sink accepts the word
// S_DONE  | done held until end_process is sampled low
module dm_result_reader #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       COUNT     = 16
) (
  input logic                clk,
  input logic                rst,
  dm_result_reader_if.master bus
);

  localparam int unsigned      IDX_W    = $clog2(COUNT) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ep_q;
  logic              armed_q;
  logic              mem_sel_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  logic [IDX_W-1:0]  idx_inc_d;
  logic [ADDR_W-1:0] addr_inc_d;
  logic              ep_rise_d;
  logic              hs_d;
  logic              at_last_d;

  // armed_q blocks a level that is already high out of reset from looking
  // like an edge; end_process must be seen low once before it can trigger.
  always_comb begin
    idx_inc_d  = idx_q + IDX_W'(1);
    addr_inc_d = BASE_ADDR + ADDR_W'(idx_inc_d);
    ep_rise_d  = bus.end_process & ~ep_q & armed_q;
    hs_d       = valid_q & bus.out_ready;
    at_last_d  = (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ep_q      <= 1'b0;
      armed_q   <= 1'b0;
      mem_sel_q <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ep_q <= bus.end_process;
      if (!bus.end_process) begin
        armed_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (ep_rise_d) begin
            state_q   <= S_FETCH;
            idx_q     <= '0;
            mem_sel_q <= 1'b1;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            addr_q    <= BASE_ADDR;
          end
        end
        S_FETCH: begin
          state_q <= S_WAIT;
          rd_en_q <= 1'b0;
          addr_q  <= '0;
        end
        S_WAIT: begin
          state_q <= S_HOLD;
          data_q  <= bus.mem_data;
          valid_q <= 1'b1;
          last_q  <= at_last_d;
        end
        S_HOLD: begin
          if (hs_d) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (at_last_d) begin
              state_q   <= S_DONE;
              mem_sel_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              idx_q   <= idx_inc_d;
              rd_en_q <= 1'b1;
              addr_q  <= addr_inc_d;
            end
          end
        end
        S_DONE: begin
          if (!bus.end_process) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_dm_result_reader.sv
// Bench for dm_result_reader: three instances (16 words at 0, 4 words
// wrapping from FFE, single word) against a word-list model of the unload.
module tb_dm_result_reader;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] ep;
  logic [2:0] rdy;
  logic [11:0] mem [4096];
  int n_cmp = 0;
  int n_bad = 0;
  int cur = 0;

  always #5 clk = ~clk;

  dm_result_reader_if #(.ADDR_W(12), .DATA_W(12)) ifa ();
  dm_result_reader_if #(.ADDR_W(12), .DATA_W(12)) ifw ();
  dm_result_reader_if #(.ADDR_W(12), .DATA_W(12)) ifs ();

  assign ifa.end_process = ep[0];
  assign ifw.end_process = ep[1];
  assign ifs.end_process = ep[2];
  assign ifa.out_ready   = rdy[0];
  assign ifw.out_ready   = rdy[1];
  assign ifs.out_ready   = rdy[2];

  // synchronous memory: data valid the cycle after the strobe, junk otherwise
  always @(posedge clk) ifa.mem_data <= ifa.mem_rd_en ? mem[ifa.mem_addr] : 12'($urandom);
  always @(posedge clk) ifw.mem_data <= ifw.mem_rd_en ? mem[ifw.mem_addr] : 12'($urandom);
  always @(posedge clk) ifs.mem_data <= ifs.mem_rd_en ? mem[ifs.mem_addr] : 12'($urandom);

  dm_result_reader #(.ADDR_W(12), .DATA_W(12), .BASE_ADDR(12'h000), .COUNT(16))
    u_a (.clk(clk), .rst(rst), .bus(ifa.master));
  dm_result_reader #(.ADDR_W(12), .DATA_W(12), .BASE_ADDR(12'hFFE), .COUNT(4))
    u_w (.clk(clk), .rst(rst), .bus(ifw.master));
  dm_result_reader #(.ADDR_W(12), .DATA_W(12), .BASE_ADDR(12'h7A5), .COUNT(1))
    u_s (.clk(clk), .rst(rst), .bus(ifs.master));

  logic m_valid, m_last, m_sel, m_rd_en, m_busy, m_done;
  logic [11:0] m_data, m_addr;

  always_comb begin
    m_valid = ifa.out_valid; m_last = ifa.out_last; m_sel = ifa.mem_sel;
    m_rd_en = ifa.mem_rd_en; m_busy = ifa.busy; m_done = ifa.done;
    m_data  = ifa.out_data;  m_addr = ifa.mem_addr;
    if (cur == 1) begin
      m_valid = ifw.out_valid; m_last = ifw.out_last; m_sel = ifw.mem_sel;
      m_rd_en = ifw.mem_rd_en; m_busy = ifw.busy; m_done = ifw.done;
      m_data  = ifw.out_data;  m_addr = ifw.mem_addr;
    end else if (cur == 2) begin
      m_valid = ifs.out_valid; m_last = ifs.out_last; m_sel = ifs.mem_sel;
      m_rd_en = ifs.mem_rd_en; m_busy = ifs.busy; m_done = ifs.done;
      m_data  = ifs.out_data;  m_addr = ifs.mem_addr;
    end
  end

  // Model: word k of an unload is mem[(base+k) mod 4096], last on k==count-1,
  // fetch k+1 the cycle after handshake k, done the cycle after the last one.
  // rmode: 0 ready tied high, 1 five-cycle stall on word 3, 2 random ready
  // with random end_process toggling while busy.
  task automatic run_unload(input int which, input int count, input int base,
                            input int rmode, input bit hold_ep,
                            input int abort_word, output bit aborted);
    int k = 0;
    int nrd = 0;
    int lasths = 0;
    int exp_fetch = 1;
    int stall = 0;
    bit got_done = 0;
    logic exp_sel;
    logic exp_last;
    logic [11:0] exp_w;
    logic [11:0] exp_a;
    aborted = 0;
    cur = which;
    rdy[which] = 1'b1;
    ep[which] = 1'b1;
    for (int cyc = 1; cyc <= 3 * count + 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && !hold_ep && rmode != 2) ep[which] = 1'b0;
      if (m_done) begin
        if (cyc != lasths + 1 || k != count) begin
          n_bad++; $display("FAIL done_time: done at cycle %0d after %0d words, need cycle %0d after %0d", cyc, k, lasths + 1, count);
        end
        n_cmp++;
        if (rmode == 0) begin
          if (cyc != 3 * count + 1) begin
            n_bad++; $display("FAIL done_latency: cycle %0d, need %0d", cyc, 3 * count + 1);
          end
          n_cmp++;
        end
        got_done = 1;
        break;
      end
      exp_sel = (k < count);
      if (m_sel !== exp_sel || m_busy !== exp_sel) begin
        n_bad++; $display("FAIL sel_busy: cycle %0d sel=%b busy=%b, need %b", cyc, m_sel, m_busy, exp_sel);
      end
      n_cmp++;
      if (m_rd_en) begin
        if (cyc != exp_fetch || nrd >= count) begin
          n_bad++; $display("FAIL fetch_cycle: read %0d at cycle %0d, need cycle %0d (count %0d)", nrd, cyc, exp_fetch, count);
        end
        n_cmp++;
        exp_a = 12'(base + nrd);
        if (m_addr !== exp_a) begin
          n_bad++; $display("FAIL fetch_addr: got %h, need %h", m_addr, exp_a);
        end
        n_cmp++;
        nrd++;
      end else begin
        if (m_addr !== 12'h000) begin
          n_bad++; $display("FAIL addr_idle: cycle %0d got %h, need 000", cyc, m_addr);
        end
        n_cmp++;
      end
      if (m_valid) begin
        if (k >= count) begin
          n_bad++; $display("FAIL extra_word: word %0d valid, only %0d expected", k, count);
        end
        n_cmp++;
        exp_w = mem[12'(base + k)];
        exp_last = (k == count - 1);
        if (m_data !== exp_w || m_last !== exp_last) begin
          n_bad++; $display("FAIL word_data: word %0d got %h last=%b, need %h last=%b", k, m_data, m_last, exp_w, exp_last);
        end
        n_cmp++;
        if (k == abort_word) begin
          aborted = 1;
          return;
        end
      end else begin
        if (m_last !== 1'b0) begin
          n_bad++; $display("FAIL last_idle: cycle %0d last=%b, need 0", cyc, m_last);
        end
        n_cmp++;
      end
      case (rmode)
        1: begin
          if (m_valid && k == 3 && stall < 5) begin
            rdy[which] = 1'b0;
            stall++;
          end else begin
            rdy[which] = 1'b1;
          end
        end
        2: rdy[which] = 1'($urandom_range(0, 1));
        default: rdy[which] = 1'b1;
      endcase
      if (m_valid && rdy[which]) begin
        lasths = cyc;
        k++;
        exp_fetch = cyc + 1;
      end
      if (rmode == 2) ep[which] = (k < count - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (!got_done) begin
      n_bad++; $display("FAIL timeout: no done, %0d of %0d words", k, count);
    end
    n_cmp++;
    if (nrd != count) begin
      n_bad++; $display("FAIL read_count: got %0d strobes, need %0d", nrd, count);
    end
    n_cmp++;
    rdy[which] = 1'b1;
    if (got_done && !hold_ep) begin
      @(negedge clk);
      if (m_done !== 1'b0) begin
        n_bad++; $display("FAIL done_exit: done=%b, need 0", m_done);
      end
      n_cmp++;
      repeat (4) begin
        @(negedge clk);
        if (m_rd_en !== 1'b0 || m_busy !== 1'b0) begin
          n_bad++; $display("FAIL quiet: rd_en=%b busy=%b, need 0 0", m_rd_en, m_busy);
        end
        n_cmp++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ep  = 3'b111;
    rdy = 3'b111;
    repeat (3) @(negedge clk);
    if ({ifa.out_valid, ifa.out_last, ifa.out_data, ifa.mem_sel, ifa.mem_rd_en, ifa.mem_addr, ifa.busy, ifa.done} !== 30'd0) begin
      n_bad++; $display("FAIL reset_a: outputs nonzero");
    end
    n_cmp++;
    if ({ifw.out_valid, ifw.out_last, ifw.out_data, ifw.mem_sel, ifw.mem_rd_en, ifw.mem_addr, ifw.busy, ifw.done} !== 30'd0) begin
      n_bad++; $display("FAIL reset_w: outputs nonzero");
    end
    n_cmp++;
    if ({ifs.out_valid, ifs.out_last, ifs.out_data, ifs.mem_sel, ifs.mem_rd_en, ifs.mem_addr, ifs.busy, ifs.done} !== 30'd0) begin
      n_bad++; $display("FAIL reset_s: outputs nonzero");
    end
    n_cmp++;
    rst = 1'b0;
    // end_process high across reset release must not start an unload
    repeat (10) begin
      @(negedge clk);
      if ({ifa.mem_rd_en, ifa.busy, ifw.mem_rd_en, ifw.busy, ifs.mem_rd_en, ifs.busy} !== 6'd0) begin
        n_bad++; $display("FAIL high_at_reset: unload started without an edge");
      end
      n_cmp++;
    end
    ep = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ab;
    for (int i = 0; i < 16; i++) mem[i] = 12'h100 + 12'(i);
    run_unload(0, 16, 0, 0, 1'b0, -1, ab);
  endtask

  task automatic test_backpressure();
    bit ab;
    run_unload(0, 16, 0, 1, 1'b0, -1, ab);
  endtask

  task automatic test_wrap();
    bit ab;
    run_unload(1, 4, 12'hFFE, 0, 1'b0, -1, ab);
    run_unload(1, 4, 12'hFFE, 2, 1'b0, -1, ab);
  endtask

  task automatic test_rearm();
    bit ab;
    run_unload(0, 16, 0, 0, 1'b1, -1, ab);
    repeat (20) begin
      @(negedge clk);
      if (m_done !== 1'b1 || m_rd_en !== 1'b0 || m_busy !== 1'b0) begin
        n_bad++; $display("FAIL rearm_hold: done=%b rd_en=%b busy=%b, need 1 0 0", m_done, m_rd_en, m_busy);
      end
      n_cmp++;
    end
    ep[0] = 1'b0;
    @(negedge clk);
    if (m_done !== 1'b0) begin
      n_bad++; $display("FAIL rearm_exit: done=%b, need 0", m_done);
    end
    n_cmp++;
    @(negedge clk);
    run_unload(0, 16, 0, 0, 1'b0, -1, ab);
  endtask

  task automatic test_random();
    bit ab;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
      run_unload(0, 16, 0, 2, 1'b0, -1, ab);
      run_unload(1, 4, 12'hFFE, 2, 1'b0, -1, ab);
    end
  endtask

  task automatic test_reset_mid();
    bit ab;
    run_unload(0, 16, 0, 0, 1'b0, 7, ab);
    if (ab !== 1'b1) begin
      n_bad++; $display("FAIL abort_reach: word 7 hold reached=%b, need 1", ab);
    end
    n_cmp++;
    rst = 1'b1;
    #1;
    if ({ifa.out_valid, ifa.out_last, ifa.out_data, ifa.mem_sel, ifa.mem_rd_en, ifa.mem_addr, ifa.busy, ifa.done} !== 30'd0) begin
      n_bad++; $display("FAIL reset_mid: valid=%b data=%h sel=%b busy=%b, need all 0", ifa.out_valid, ifa.out_data, ifa.mem_sel, ifa.busy);
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_unload(0, 16, 0, 0, 1'b0, -1, ab);
  endtask

  task automatic test_count1();
    bit ab;
    run_unload(2, 1, 12'h7A5, 0, 1'b0, -1, ab);
    run_unload(2, 1, 12'h7A5, 2, 1'b0, -1, ab);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_rearm();
    test_count1();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
